// File: rtl/uart_tx_engine_if.sv
// Bus between the UART register block and the transmit engine.
// The register block drives the i_* signals; the engine drives the o_* status and line.
interface uart_tx_engine_if;
   logic        i_enable;
   logic [15:0] i_baud_div;
   logic        i_write;
   logic [7:0]  i_data;
   logic        o_ready;
   logic        o_empty;
   logic        o_active;
   logic        o_tx;

   modport master (
      output i_enable,
      output i_baud_div,
      output i_write,
      output i_data,
      input  o_ready,
      input  o_empty,
      input  o_active,
      input  o_tx
   );

   modport slave (
      input  i_enable,
      input  i_baud_div,
      input  i_write,
      input  i_data,
      output o_ready,
      output o_empty,
      output o_active,
      output o_tx
   );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8N1 serialiser, LSB first, registered o_tx.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data bits and the stop bit.
module uart_tx_engine #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   uart_tx_engine_if.slave   bus
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    head;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_q, tx_d;

   logic          push;
   logic          pop;
   logic          can_start;
   logic          bit_end;

   // Full check uses the pre-edge count, so a push into a full FIFO is lost
   // even when the same cycle pops.
   assign push      = bus.i_write && (count != FULL);
   assign can_start = bus.i_enable && (count != '0);
   assign bit_end   = (cnt_q == '0);
   assign head      = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            pop  = can_start;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = div_q;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = div_q;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = par_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               cnt_d   = div_q;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
               pop     = can_start;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Frame launch is shared by IDLE and the last stop-bit cycle, which
      // gives back-to-back frames with no idle gap.
      if (pop) begin
         state_d = S_START;
         tx_d    = 1'b0;
         cnt_d   = bus.i_baud_div;
         div_d   = bus.i_baud_div;
         shift_d = head;
         par_d   = ^head;
      end
   end

   assign bus.o_ready  = (count != FULL);
   assign bus.o_empty  = (count == '0);
   assign bus.o_active = (state_q != S_IDLE);
   assign bus.o_tx     = tx_q;

endmodule
